// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        FILLING = 2'b01,
        ARMED   = 2'b10
    } fill_state_t;

    // Increment that sticks at the all-ones value of a 'width'-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_sat_counter.sv
// Saturating event counter with a sticky saturation flag.
// Latency: count/sat update on the falling edge that samples inc/clr.
// Backpressure: none; clr has priority over inc, inc=0 holds.
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             n_clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_inc;

    // Next value if an event arrives; holds once all-ones is reached
    always_comb begin
        count_inc = CNT_W'(sat_inc(32'(count), CNT_W));
    end

    // Count events; clear wins over a same-edge event, sat stays set until cleared
    always_ff @(negedge n_clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            count <= count_inc;
            if (&count_inc) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_p.sv
// Detects a loadable PAT_W-bit pattern on serial input a, counting matches.
// Latency: match pulses for one cycle after the edge sampling the last pattern bit.
// Backpressure: none; en=0 freezes history/fill/count, load restarts history.
module seq_detect_p
    import seq_detect_pkg::*;
#(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic             n_clk,
    input  logic             rst,
    input  logic             a,
    input  logic             en,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic [1:0]       state_o
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill;
    fill_state_t      state;

    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill_n;
    logic [FW-1:0]    fill_upd;
    logic             hit;
    fill_state_t      state_n;

    // Next history/fill for a sampled bit and the resulting hit decision
    always_comb begin
        hist_n   = {hist[PAT_W-2:0], a};
        fill_n   = (fill == FULL) ? fill : fill + FW'(1);
        hit      = en && !load && (fill_n == FULL) && (hist_n == pat_q);
        fill_upd = (hit && (OVERLAP == 0)) ? '0 : fill_n;
        if (fill_upd == '0) begin
            state_n = EMPTY;
        end else if (fill_upd == FULL) begin
            state_n = ARMED;
        end else begin
            state_n = FILLING;
        end
    end

    // Fill-tracking FSM: load restarts, enabled edges shift in a bit, match is registered
    always_ff @(negedge n_clk or negedge rst) begin
        if (!rst) begin
            pat_q <= '0;
            hist  <= '0;
            fill  <= '0;
            state <= EMPTY;
            match <= 1'b0;
        end else if (load) begin
            pat_q <= pattern;
            hist  <= '0;
            fill  <= '0;
            state <= EMPTY;
            match <= 1'b0;
        end else if (en) begin
            hist  <= hist_n;
            fill  <= fill_upd;
            state <= state_n;
            match <= hit;
        end else begin
            match <= 1'b0;
        end
    end

    assign state_o = state;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .n_clk (n_clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (clr),
        .count (count),
        .sat   (sat)
    );

endmodule

// File: tb/tb_seq_detect_p.sv
module tb_seq_detect_p;

    logic       n_clk;
    logic       rst;
    logic       a;
    logic       en;
    logic       load;
    logic       clr;
    logic [3:0] pattern;

    logic       d_m  [3];
    logic [7:0] d_c  [3];
    logic       d_s  [3];
    logic [1:0] d_st [3];
    logic [1:0] c2;

    assign d_c[2] = {6'd0, c2};

    // u0: overlapping, u1: non-overlapping, u2: overlapping with a 2-bit counter
    seq_detect_p #(.PAT_W(4), .CNT_W(8), .OVERLAP(1)) u0 (
        .n_clk(n_clk), .rst(rst), .a(a), .en(en), .load(load), .pattern(pattern), .clr(clr),
        .match(d_m[0]), .count(d_c[0]), .sat(d_s[0]), .state_o(d_st[0]));
    seq_detect_p #(.PAT_W(4), .CNT_W(8), .OVERLAP(0)) u1 (
        .n_clk(n_clk), .rst(rst), .a(a), .en(en), .load(load), .pattern(pattern), .clr(clr),
        .match(d_m[1]), .count(d_c[1]), .sat(d_s[1]), .state_o(d_st[1]));
    seq_detect_p #(.PAT_W(4), .CNT_W(2), .OVERLAP(1)) u2 (
        .n_clk(n_clk), .rst(rst), .a(a), .en(en), .load(load), .pattern(pattern), .clr(clr),
        .match(d_m[2]), .count(c2), .sat(d_s[2]), .state_o(d_st[2]));

    initial begin
        n_clk = 1'b1;
        forever #5 n_clk = ~n_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the whole sampled stream plus, per instance, where its
    // current match window begins. A hit is "at least 4 bits since the window
    // start and the last 4 received bits spell the pattern, oldest first".
    localparam int CMAX [3] = '{255, 255, 3};
    localparam bit OVL  [3] = '{1'b1, 1'b0, 1'b1};
    bit         stream [$];
    int         start  [3];
    int         cnt_m  [3];
    bit         sat_m  [3];
    bit         mt_m   [3];
    logic [3:0] pat_m;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit window_hit(int i);
        int n;
        int sz;
        sz = stream.size();
        n  = sz - start[i];
        if (n < 4) return 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (stream[sz - 4 + k] != pat_m[3 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int exp_state(int i);
        int n;
        n = stream.size() - start[i];
        if (n == 0) return 0;
        if (n >= 4) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        pat_m = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            start[i] = stream.size();
            cnt_m[i] = 0;
            sat_m[i] = 1'b0;
            mt_m[i]  = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_match", i), int'(d_m[i]),  int'(mt_m[i]));
            chk($sformatf("u%0d_count", i), int'(d_c[i]),  cnt_m[i]);
            chk($sformatf("u%0d_sat", i),   int'(d_s[i]),  int'(sat_m[i]));
            chk($sformatf("u%0d_state", i), int'(d_st[i]), exp_state(i));
        end
    endtask

    // One falling edge with the given inputs, then model update and compare
    task automatic step(input logic l, input logic e, input logic b, input logic c, input logic [3:0] p);
        bit hitv [3];
        load = l; en = e; a = b; clr = c; pattern = p;
        @(negedge n_clk);
        #1;
        for (int i = 0; i < 3; i++) hitv[i] = 1'b0;
        if (l) begin
            pat_m = p;
            for (int i = 0; i < 3; i++) begin
                start[i] = stream.size();
                mt_m[i]  = 1'b0;
            end
        end else if (e) begin
            stream.push_back(b);
            for (int i = 0; i < 3; i++) begin
                hitv[i] = window_hit(i);
                mt_m[i] = hitv[i];
                if (hitv[i] && !OVL[i]) start[i] = stream.size();
            end
        end else begin
            for (int i = 0; i < 3; i++) mt_m[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                cnt_m[i] = 0;
                sat_m[i] = 1'b0;
            end else if (hitv[i]) begin
                if (cnt_m[i] < CMAX[i]) cnt_m[i]++;
                if (cnt_m[i] == CMAX[i]) sat_m[i] = 1'b1;
            end
        end
        compare_all();
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock
    task automatic arst_pulse();
        #3;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_arst_match", i), int'(d_m[i]),  0);
            chk($sformatf("u%0d_arst_count", i), int'(d_c[i]),  0);
            chk($sformatf("u%0d_arst_sat", i),   int'(d_s[i]),  0);
            chk($sformatf("u%0d_arst_state", i), int'(d_st[i]), 0);
        end
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    task automatic feed(input logic [3:0] bits, input int nb);
        for (int k = nb - 1; k >= 0; k--) step(1'b0, 1'b1, bits[k], 1'b0, 4'h0);
    endtask

    initial begin
        rst = 1'b0; a = 1'b0; en = 1'b0; load = 1'b0; clr = 1'b0; pattern = 4'h0;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_rst_count", i), int'(d_c[i]),  0);
            chk($sformatf("u%0d_rst_state", i), int'(d_st[i]), 0);
        end
        rst = 1'b1;

        // Basic detection and overlap behaviour
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
        feed(4'b1011, 4);
        feed(4'b0110, 3);

        // Saturation on a 2-bit counter, then clear on a hit edge
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);

        // Reset while filling; fresh bits required afterwards
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
        feed(4'b0010, 2);
        arst_pulse();
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
        feed(4'b1011, 4);

        // Enable gaps do not break or create a match
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
        feed(4'b0010, 2);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, k[0], 1'b0, 4'hF);
        feed(4'b0011, 2);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) arst_pulse();
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
